// File: rtl/rob_pkg.sv
// rob_pkg: shared widths for the reorder buffer.
//   DataLength    - highest bit of a result value
//   PcLength      - highest bit of a PC / tag
//   OpcodeLength  - highest bit of an opcode
//   RegAddrLength - highest bit of a register index
package rob_pkg;

    localparam int DataLength    = 31;
    localparam int PcLength      = 31;
    localparam int OpcodeLength  = 6;
    localparam int RegAddrLength = 4;

endpackage

// File: rtl/rob.sv
// rob: reorder buffer, a circular queue of in-flight instructions.
// Allocates in program order from the decoder, captures ALU results by PC tag,
// retires the head in order and flushes everything on a mispredicted jump.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   *_from_dc                 dispatch request (is_empty low = valid), pc/op/rd
//   *_from_alu                write-back (is_empty low = valid), tag/data/jump/target
//   is_ready_to_iq            registered: dispatch may proceed
//   is_commit_to_rs, commit_* one-cycle retire strobe with pc/data/rd
//   is_exception_to_rs        one-cycle flush strobe, target_pc_to_if = redirect
module rob
    import rob_pkg::*;
#(
    parameter int RobLength     = 15,
    parameter int PointerLength = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   is_empty_from_dc,
    input  logic [OpcodeLength:0]  op_from_dc,
    input  logic [PcLength:0]      pc_from_dc,
    input  logic [RegAddrLength:0] rd_from_dc,
    input  logic                   is_empty_from_alu,
    input  logic [PcLength:0]      pc_from_alu,
    input  logic [DataLength:0]    data_from_alu,
    input  logic                   is_jump_from_alu,
    input  logic [PcLength:0]      target_pc_from_alu,
    output logic                   is_ready_to_iq,
    output logic                   is_commit_to_rs,
    output logic [PcLength:0]      commit_pc_to_rs,
    output logic [DataLength:0]    commit_data_to_rs,
    output logic [RegAddrLength:0] commit_rd_to_rf,
    output logic                   is_exception_to_rs,
    output logic [PcLength:0]      target_pc_to_if
);

    localparam int PtrW = PointerLength + 1;
    localparam int CntW = PointerLength + 2;
    localparam logic [PtrW-1:0] LastIdx  = PtrW'(RobLength);
    localparam logic [CntW-1:0] FullCnt  = CntW'(RobLength + 1);
    localparam logic [CntW-1:0] ReadyMax = CntW'(RobLength - 2);

    // Entry state
    logic [RobLength:0]     busy_q, busy_d, done_q, done_d, jump_q, jump_d;
    logic [PcLength:0]      pc_q     [0:RobLength];
    logic [PcLength:0]      pc_d     [0:RobLength];
    logic [OpcodeLength:0]  op_q     [0:RobLength];
    logic [OpcodeLength:0]  op_d     [0:RobLength];
    logic [RegAddrLength:0] rd_q     [0:RobLength];
    logic [RegAddrLength:0] rd_d     [0:RobLength];
    logic [DataLength:0]    data_q   [0:RobLength];
    logic [DataLength:0]    data_d   [0:RobLength];
    logic [PcLength:0]      target_q [0:RobLength];
    logic [PcLength:0]      target_d [0:RobLength];

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    // Registered outputs
    logic                   ready_q, ready_d;
    logic                   commit_q, commit_d;
    logic [PcLength:0]      commit_pc_q, commit_pc_d;
    logic [DataLength:0]    commit_data_q, commit_data_d;
    logic [RegAddrLength:0] commit_rd_q, commit_rd_d;
    logic                   exc_q, exc_d;
    logic [PcLength:0]      redirect_q, redirect_d;

    logic alloc_s, commit_s, flush_s;

    // Next-state: write-back, commit/flush, allocation, count and ready
    always_comb begin
        busy_d   = busy_q;
        done_d   = done_q;
        jump_d   = jump_q;
        pc_d     = pc_q;
        op_d     = op_q;
        rd_d     = rd_q;
        data_d   = data_q;
        target_d = target_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        commit_d      = 1'b0;
        exc_d         = 1'b0;
        commit_pc_d   = commit_pc_q;
        commit_data_d = commit_data_q;
        commit_rd_d   = commit_rd_q;
        redirect_d    = redirect_q;

        // Commit looks only at registered flags, so a result written back
        // this cycle cannot retire until the following cycle.
        commit_s = busy_q[head_q] & done_q[head_q];
        flush_s  = commit_s & jump_q[head_q];
        alloc_s  = ~is_empty_from_dc & (count_q < FullCnt);

        // Tag-matched write-back; unmatched tags are stale and dropped
        if (!is_empty_from_alu) begin
            for (int i = 0; i <= RobLength; i++) begin
                if (busy_q[i] && (pc_q[i] == pc_from_alu)) begin
                    done_d[i]   = 1'b1;
                    data_d[i]   = data_from_alu;
                    jump_d[i]   = is_jump_from_alu;
                    target_d[i] = target_pc_from_alu;
                end else begin
                    done_d[i]   = done_d[i];
                end
            end
        end else begin
            done_d = done_d;
        end

        if (commit_s) begin
            commit_d      = 1'b1;
            commit_pc_d   = pc_q[head_q];
            commit_data_d = data_q[head_q];
            commit_rd_d   = rd_q[head_q];
            if (flush_s) begin
                // Flush wins over this cycle's allocate and write-back
                exc_d      = 1'b1;
                redirect_d = target_q[head_q];
                busy_d     = '0;
                done_d     = '0;
                head_d     = '0;
                tail_d     = '0;
            end else begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d = (head_q == LastIdx) ? '0 : head_q + PtrW'(1);
            end
        end else begin
            commit_d = 1'b0;
        end

        if (alloc_s && !flush_s) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            jump_d[tail_q] = 1'b0;
            pc_d[tail_q]   = pc_from_dc;
            op_d[tail_q]   = op_from_dc;
            rd_d[tail_q]   = rd_from_dc;
            tail_d = (tail_q == LastIdx) ? '0 : tail_q + PtrW'(1);
        end else begin
            tail_d = tail_d;
        end

        if (flush_s) begin
            count_d = '0;
        end else if (alloc_s && !commit_s) begin
            count_d = count_q + CntW'(1);
        end else if (!alloc_s && commit_s) begin
            count_d = count_q - CntW'(1);
        end else begin
            count_d = count_q;
        end

        // Two-slot margin absorbs the one-cycle lag of this registered flag
        ready_d = (count_d <= ReadyMax);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            done_q  <= '0;
            jump_q  <= '0;
            for (int i = 0; i <= RobLength; i++) begin
                pc_q[i]     <= '0;
                op_q[i]     <= '0;
                rd_q[i]     <= '0;
                data_q[i]   <= '0;
                target_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            commit_q      <= 1'b0;
            commit_pc_q   <= '0;
            commit_data_q <= '0;
            commit_rd_q   <= '0;
            exc_q         <= 1'b0;
            redirect_q    <= '0;
        end else begin
            busy_q        <= busy_d;
            done_q        <= done_d;
            jump_q        <= jump_d;
            pc_q          <= pc_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            data_q        <= data_d;
            target_q      <= target_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
            commit_q      <= commit_d;
            commit_pc_q   <= commit_pc_d;
            commit_data_q <= commit_data_d;
            commit_rd_q   <= commit_rd_d;
            exc_q         <= exc_d;
            redirect_q    <= redirect_d;
        end
    end

    assign is_ready_to_iq     = ready_q;
    assign is_commit_to_rs    = commit_q;
    assign commit_pc_to_rs    = commit_pc_q;
    assign commit_data_to_rs  = commit_data_q;
    assign commit_rd_to_rf    = commit_rd_q;
    assign is_exception_to_rs = exc_q;
    assign target_pc_to_if    = redirect_q;

endmodule

// File: tb/tb_rob.sv
// tb_rob: directed self-checking bench for the reorder buffer.
module tb_rob;
    import rob_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   is_empty_from_dc = 1'b1;
    logic [OpcodeLength:0]  op_from_dc = 7'h13;
    logic [PcLength:0]      pc_from_dc = 32'h0;
    logic [RegAddrLength:0] rd_from_dc = 5'd0;
    logic                   is_empty_from_alu = 1'b1;
    logic [PcLength:0]      pc_from_alu = 32'h0;
    logic [DataLength:0]    data_from_alu = 32'h0;
    logic                   is_jump_from_alu = 1'b0;
    logic [PcLength:0]      target_pc_from_alu = 32'h0;
    logic                   is_ready_to_iq;
    logic                   is_commit_to_rs;
    logic [PcLength:0]      commit_pc_to_rs;
    logic [DataLength:0]    commit_data_to_rs;
    logic [RegAddrLength:0] commit_rd_to_rf;
    logic                   is_exception_to_rs;
    logic [PcLength:0]      target_pc_to_if;

    rob dut (
        .clk                (clk),
        .rst                (rst),
        .is_empty_from_dc   (is_empty_from_dc),
        .op_from_dc         (op_from_dc),
        .pc_from_dc         (pc_from_dc),
        .rd_from_dc         (rd_from_dc),
        .is_empty_from_alu  (is_empty_from_alu),
        .pc_from_alu        (pc_from_alu),
        .data_from_alu      (data_from_alu),
        .is_jump_from_alu   (is_jump_from_alu),
        .target_pc_from_alu (target_pc_from_alu),
        .is_ready_to_iq     (is_ready_to_iq),
        .is_commit_to_rs    (is_commit_to_rs),
        .commit_pc_to_rs    (commit_pc_to_rs),
        .commit_data_to_rs  (commit_data_to_rs),
        .commit_rd_to_rf    (commit_rd_to_rf),
        .is_exception_to_rs (is_exception_to_rs),
        .target_pc_to_if    (target_pc_to_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        exc;
        logic [31:0] tgt;
    } rec_t;

    rec_t obs_q[$];
    rec_t exp_q[$];
    int   exc_pulses = 0;
    int   checks     = 0;
    int   failures   = 0;

    // Record every commit strobe at the falling edge, away from the active edge
    always @(negedge clk) begin
        if (is_commit_to_rs) begin
            obs_q.push_back('{commit_pc_to_rs, commit_data_to_rs, commit_rd_to_rf,
                              is_exception_to_rs, target_pc_to_if});
        end
        if (is_exception_to_rs) exc_pulses++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus, then back to idle inputs
    task automatic cyc(input logic dv, input logic [31:0] dpc, input logic [4:0] drd,
                       input logic av, input logic [31:0] apc, input logic [31:0] ad,
                       input logic aj, input logic [31:0] at);
        is_empty_from_dc   = ~dv;
        pc_from_dc         = dpc;
        rd_from_dc         = drd;
        is_empty_from_alu  = ~av;
        pc_from_alu        = apc;
        data_from_alu      = ad;
        is_jump_from_alu   = aj;
        target_pc_from_alu = at;
        tick();
        is_empty_from_dc   = 1'b1;
        is_empty_from_alu  = 1'b1;
        is_jump_from_alu   = 1'b0;
    endtask

    task automatic dispatch(input logic [31:0] pc, input logic [4:0] rd);
        cyc(1'b1, pc, rd, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wb(input logic [31:0] pc, input logic [31:0] d, input logic j, input logic [31:0] t);
        cyc(1'b0, 32'h0, 5'd0, 1'b1, pc, d, j, t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_commit(input logic [31:0] pc, input logic [31:0] d, input logic [4:0] rd,
                                 input logic exc, input logic [31:0] tgt);
        exp_q.push_back('{pc, d, rd, exc, tgt});
    endtask

    task automatic verify_commits(input string tag);
        int n;
        check_eq($sformatf("%s_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_pc%0d", tag, i), 64'(obs_q[i].pc), 64'(exp_q[i].pc));
            check_eq($sformatf("%s_data%0d", tag, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
            check_eq($sformatf("%s_rd%0d", tag, i), 64'(obs_q[i].rd), 64'(exp_q[i].rd));
            check_eq($sformatf("%s_exc%0d", tag, i), 64'(obs_q[i].exc), 64'(exp_q[i].exc));
            if (exp_q[i].exc)
                check_eq($sformatf("%s_tgt%0d", tag, i), 64'(obs_q[i].tgt), 64'(exp_q[i].tgt));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic ready_ok;

        // Reset state
        rst = 1'b1;
        idle(2);
        check_eq("rst_ready", 64'(is_ready_to_iq), 64'd1);
        check_eq("rst_commit", 64'(is_commit_to_rs), 64'd0);
        check_eq("rst_exc", 64'(is_exception_to_rs), 64'd0);
        check_eq("rst_cpc", 64'(commit_pc_to_rs), 64'd0);
        check_eq("rst_cdata", 64'(commit_data_to_rs), 64'd0);
        check_eq("rst_crd", 64'(commit_rd_to_rf), 64'd0);
        check_eq("rst_tgt", 64'(target_pc_to_if), 64'd0);
        rst = 1'b0;
        tick();

        // Out-of-order write-back, in-order retirement
        dispatch(32'h4, 5'd1);
        dispatch(32'h8, 5'd2);
        dispatch(32'hC, 5'd3);
        wb(32'hC, 32'd30, 1'b0, 32'h0);
        wb(32'h4, 32'd10, 1'b0, 32'h0);
        wb(32'h8, 32'd20, 1'b0, 32'h0);
        idle(6);
        expect_commit(32'h4, 32'd10, 5'd1, 1'b0, 32'h0);
        expect_commit(32'h8, 32'd20, 5'd2, 1'b0, 32'h0);
        expect_commit(32'hC, 32'd30, 5'd3, 1'b0, 32'h0);
        verify_commits("order");
        check_eq("hold_commit", 64'(is_commit_to_rs), 64'd0);
        check_eq("hold_cpc", 64'(commit_pc_to_rs), 64'hC);
        check_eq("hold_cdata", 64'(commit_data_to_rs), 64'd30);

        // Fill to 16, ready drops after the 14th, 17th dropped
        for (int k = 1; k <= 16; k++) begin
            dispatch(32'h100 + 32'(4 * (k - 1)), 5'(k));
            check_eq($sformatf("fill_ready%0d", k), 64'(is_ready_to_iq), 64'(k <= 13));
        end
        dispatch(32'h200, 5'd31);
        wb(32'h200, 32'hDEAD, 1'b0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            wb(32'h100 + 32'(4 * k), 32'(3 * k + 1), 1'b0, 32'h0);
            expect_commit(32'h100 + 32'(4 * k), 32'(3 * k + 1), 5'(k + 1), 1'b0, 32'h0);
        end
        idle(6);
        verify_commits("full");
        check_eq("full_ready_back", 64'(is_ready_to_iq), 64'd1);

        // Mispredicted jump flushes after the older instruction retires
        dispatch(32'h4, 5'd1);
        dispatch(32'h8, 5'd2);
        dispatch(32'hC, 5'd3);
        wb(32'h8, 32'h0000000C, 1'b1, 32'h100);
        wb(32'h4, 32'd10, 1'b0, 32'h0);
        idle(5);
        wb(32'hC, 32'd99, 1'b0, 32'h0);
        idle(5);
        expect_commit(32'h4, 32'd10, 5'd1, 1'b0, 32'h0);
        expect_commit(32'h8, 32'h0000000C, 5'd2, 1'b1, 32'h100);
        verify_commits("jump");
        check_eq("jump_exc_pulses", 64'(exc_pulses), 64'd1);
        check_eq("jump_ready", 64'(is_ready_to_iq), 64'd1);
        check_eq("jump_tgt_hold", 64'(target_pc_to_if), 64'h100);

        // Steady stream: dispatch k while writing back k-1
        ready_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 32'h1000 + 32'(4 * k), 5'((k % 31) + 1),
                k > 0, 32'h1000 + 32'(4 * (k - 1)), 32'(k - 1) ^ 32'h55, 1'b0, 32'h0);
            if (!is_ready_to_iq) ready_ok = 1'b0;
            expect_commit(32'h1000 + 32'(4 * k), 32'(k) ^ 32'h55, 5'((k % 31) + 1), 1'b0, 32'h0);
        end
        wb(32'h1000 + 32'(4 * 39), 32'(39) ^ 32'h55, 1'b0, 32'h0);
        idle(6);
        verify_commits("stream");
        check_eq("stream_ready", 64'(ready_ok), 64'd1);

        // Reset with five busy entries, head about to commit
        for (int k = 0; k < 5; k++) dispatch(32'h40 + 32'(4 * k), 5'(k + 1));
        wb(32'h40, 32'd5, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_commit", 64'(is_commit_to_rs), 64'd0);
        check_eq("mid_rst_exc", 64'(is_exception_to_rs), 64'd0);
        check_eq("mid_rst_ready", 64'(is_ready_to_iq), 64'd1);
        idle(4);
        verify_commits("mid_rst");
        dispatch(32'h4, 5'd7);
        wb(32'h4, 32'd77, 1'b0, 32'h0);
        idle(5);
        expect_commit(32'h4, 32'd77, 5'd7, 1'b0, 32'h0);
        verify_commits("after_rst");
        check_eq("total_exc_pulses", 64'(exc_pulses), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
